button_pulse_gen: RTL and testbench
===================================

# button_pulse_gen

Debounces a raw, asynchronous push-button input and emits a single-cycle press pulse for every clean press and a single-cycle release pulse for every clean release. It sits directly upstream of the board's toggle-style control flip-flops, such as run/halt: Press_Pulse drives their D input with WE tied high, so each physical press flips the downstream state exactly once. It also provides a clean debounced level for status LEDs.

## Interface
- STABLE_CYCLES, default 50000: consecutive stable synchronized samples required to accept a level change (1 ms at 50 MHz); legal range ≥ 2.
- CNT_W, default $clog2(STABLE_CYCLES): width of the stability counter.

- Clk  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Btn_In  in  1  raw button, active-high, asynchronous to Clk, bouncy.
- Btn_Level  out  1  debounced button level.
- Press_Pulse  out  1  one-cycle strobe on accepted 0→1.
- Release_Pulse  out  1  one-cycle strobe on accepted 1→0.

## Operation
- Btn_In passes through a 2-flop synchronizer; s_btn is the second flop's output. Both flops reset to 0.
- FSM states:
  - IDLE (level 0): if s_btn=1, go to PRESS_WAIT and set cnt=0.
  - PRESS_WAIT: if s_btn=0, return to IDLE and set cnt=0. Else if cnt==STABLE_CYCLES-1, go to HELD and set cnt=0. Else increment cnt.
  - HELD (level 1): if s_btn=0, go to REL_WAIT and set cnt=0.
  - REL_WAIT: if s_btn=1, return to HELD and set cnt=0. Else if cnt==STABLE_CYCLES-1, go to IDLE and set cnt=0. Else increment cnt.
- Btn_Level is a registered 1 in HELD and REL_WAIT, and 0 otherwise.
- Press_Pulse is registered and high for exactly the one cycle following the PRESS_WAIT→HELD edge.
- Release_Pulse is registered and high for exactly the one cycle following the REL_WAIT→IDLE edge.
- A bounce during a WAIT state aborts it. No pulse is generated and Btn_Level is unchanged.
- cnt saturates logically at STABLE_CYCLES-1 and never wraps. It is unsigned, CNT_W bits.
- Press_Pulse and Release_Pulse are never high in the same cycle, and never high on consecutive cycles.

## Timing
- Reset values: Btn_Level=0, Press_Pulse=0, Release_Pulse=0, state=IDLE, cnt=0, synchronizer=00.
- Reset takes precedence over all transitions. Asserting it mid-WAIT aborts the change, and no pulse appears in the cycle after the reset edge.
- A button held through reset counts as a new press after Reset deasserts and produces Press_Pulse after the full latency.
- Press latency: Btn_In high and stable, first sampled at edge 1, gives Press_Pulse=1 and Btn_Level=1 after edge STABLE_CYCLES+3. Pulse width is exactly 1 cycle.
- Release latency is symmetric: Release_Pulse=1 and Btn_Level=0 after edge STABLE_CYCLES+3.
- A low glitch shorter than STABLE_CYCLES synchronized cycles while HELD produces no pulses.

## Structure
- Shared package (lc3_misc_pkg): FSM state encoding constants IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, REL_WAIT=2'd3.
- Sub-module: sync_2ff, a generic 2-flop synchronizer with Clk and Reset (reset to 0). It is reusable for the other board inputs.
- The top level contains the FSM, the counter and the output registers.

## Test plan
All scenarios use STABLE_CYCLES=4.
- Reset: hold Reset 3 cycles with Btn_In=0 → all outputs 0. Release Reset and hold 20 idle cycles → outputs remain 0.
- Clean press: raise Btn_In, first sampled at edge 1, and hold → Press_Pulse=1 only in the cycle after edge 7, Btn_Level=1 from edge 7 onward. Drop Btn_In → Release_Pulse=1 exactly 7 edges later, Btn_Level=0.
- Bounce: Btn_In pattern 1,0,1,1,0,1 then steady 1 → exactly one Press_Pulse, 7 edges after the final rise. No Release_Pulse.
- Release glitch: while HELD, drop Btn_In low for 2 cycles → no pulses, Btn_Level stays 1.
- Reset mid-operation: assert Reset during PRESS_WAIT (cnt=2) → no Press_Pulse and Btn_Level=0. With Btn_In still high after Reset drops → Press_Pulse 7 edges after deassertion.
- Downstream integration: drive a toggle flip-flop with D=Press_Pulse, WE=1. Three clean presses → its Q toggles 0→1→0→1, once per press.

Source files
------------

// File: rtl/lc3_misc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lc3_misc_pkg : shared state encoding for the board input conditioners |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package lc3_misc_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } btn_state_e;

  // The debounced level is high while the button is accepted as pressed,
  // including while a release is still being qualified.
  function automatic logic btn_level_of(input btn_state_e s);
    return (s == HELD) || (s == REL_WAIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_pulse_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | button_pulse_gen_if : raw button in, debounced level and strobes out  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface button_pulse_gen_if;
  logic Btn_In;
  logic Btn_Level;
  logic Press_Pulse;
  logic Release_Pulse;

  modport master (
    output Btn_In,
    input  Btn_Level,
    input  Press_Pulse,
    input  Release_Pulse
  );

  modport slave (
    input  Btn_In,
    output Btn_Level,
    output Press_Pulse,
    output Release_Pulse
  );
endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff : generic two-flop synchronizer, synchronous reset to 0      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/button_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | button_pulse_gen : debounced button level plus press/release strobes  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module button_pulse_gen
  import lc3_misc_pkg::*;
#(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic                Clk,
  input  logic                Reset,
  button_pulse_gen_if.slave   btn
);

  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(STABLE_CYCLES - 1);

  logic             w_s_btn;
  btn_state_e       r_state;
  btn_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             w_press;
  logic             w_release;

  sync_2ff #(
    .WIDTH (1)
  ) u_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .i_d   (btn.Btn_In),
    .o_q   (w_s_btn)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= btn_level_of(w_state_nxt);
      r_press   <= w_press;
      r_release <= w_release;
    end
  end

  // Any disagreeing sample during a WAIT state drops back to the level
  // that was already accepted; the counter restarts on every entry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_s_btn) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_s_btn) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_max) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!w_s_btn) begin
          w_state_nxt = REL_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      REL_WAIT: begin
        if (w_s_btn) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_max) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_press   = (r_state == PRESS_WAIT) && (w_state_nxt == HELD);
  assign w_release = (r_state == REL_WAIT)   && (w_state_nxt == IDLE);

  assign btn.Btn_Level     = r_level;
  assign btn.Press_Pulse   = r_press;
  assign btn.Release_Pulse = r_release;

endmodule
`default_nettype wire

// File: tb/tb_button_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_button_pulse_gen : directed checks of debounce latency and strobes |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_button_pulse_gen;

  localparam int c_stable = 4;

  logic Clk;
  logic Reset;
  logic r_tq;

  int n_checks;
  int n_errors;

  int press_cnt;
  int rel_cnt;
  int press_at;
  int rel_at;
  int lvl_chg_at;
  int lvl_lo_cnt;
  int rule_viol;

  button_pulse_gen_if u_if ();

  button_pulse_gen #(
    .STABLE_CYCLES (c_stable)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .btn   (u_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Downstream toggle flip-flop: D driven by the press strobe, WE tied high.
  always @(posedge Clk) begin
    if (Reset) r_tq <= 1'b0;
    else       r_tq <= r_tq ^ u_if.Press_Pulse;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drives Btn_In from pat (LSB first, last bit held) for n edges, recording
  // relative edge numbers (1 = first edge that samples the new input).
  task automatic drive_watch(input int n, input logic [15:0] pat, input int plen);
    logic lvl0;
    logic prev_any;
    press_cnt  = 0;
    rel_cnt    = 0;
    press_at   = 0;
    rel_at     = 0;
    lvl_chg_at = 0;
    lvl_lo_cnt = 0;
    prev_any   = 1'b0;
    lvl0       = u_if.Btn_Level;
    for (int k = 1; k <= n; k++) begin
      u_if.Btn_In = (k <= plen) ? pat[k-1] : pat[plen-1];
      @(posedge Clk);
      #1;
      if (u_if.Press_Pulse) begin
        press_cnt++;
        if (press_at == 0) press_at = k;
      end
      if (u_if.Release_Pulse) begin
        rel_cnt++;
        if (rel_at == 0) rel_at = k;
      end
      if ((u_if.Btn_Level !== lvl0) && (lvl_chg_at == 0)) lvl_chg_at = k;
      if (!u_if.Btn_Level) lvl_lo_cnt++;
      if (u_if.Press_Pulse && u_if.Release_Pulse) rule_viol++;
      if ((u_if.Press_Pulse || u_if.Release_Pulse) && prev_any) rule_viol++;
      prev_any = u_if.Press_Pulse || u_if.Release_Pulse;
    end
  endtask

  task automatic tick_reset(input int n);
    Reset = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge Clk);
      #1;
    end
    Reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rule_viol   = 0;
    Reset       = 1'b1;
    u_if.Btn_In = 1'b0;

    // Reset state
    tick_reset(3);
    chk("rst_level",   u_if.Btn_Level,     0);
    chk("rst_press",   u_if.Press_Pulse,   0);
    chk("rst_release", u_if.Release_Pulse, 0);

    drive_watch(20, 16'h0000, 1);
    chk("idle_press",   press_cnt,  0);
    chk("idle_release", rel_cnt,    0);
    chk("idle_level",   lvl_chg_at, 0);

    // Clean press: pulse and level both appear at edge STABLE_CYCLES+3
    drive_watch(10, 16'h0001, 1);
    chk("press_count",   press_cnt,      1);
    chk("press_edge",    press_at,       7);
    chk("press_lvl_edge", lvl_chg_at,    7);
    chk("press_no_rel",  rel_cnt,        0);
    chk("press_lvl_end", u_if.Btn_Level, 1);

    // Clean release
    drive_watch(10, 16'h0000, 1);
    chk("rel_count",    rel_cnt,        1);
    chk("rel_edge",     rel_at,         7);
    chk("rel_lvl_edge", lvl_chg_at,     7);
    chk("rel_no_press", press_cnt,      0);
    chk("rel_lvl_end",  u_if.Btn_Level, 0);

    // Bounce 1,0,1,1,0,1 then steady: final rise at edge 6, pulse at edge 12
    drive_watch(16, 16'b101101, 6);
    chk("bounce_count",  press_cnt, 1);
    chk("bounce_edge",   press_at,  12);
    chk("bounce_no_rel", rel_cnt,   0);

    // Two-cycle low glitch while held
    drive_watch(14, 16'b100, 3);
    chk("glitch_press", press_cnt,  0);
    chk("glitch_rel",   rel_cnt,    0);
    chk("glitch_level", lvl_lo_cnt, 0);

    drive_watch(10, 16'h0000, 1);
    chk("rel2_edge",  rel_at,         7);
    chk("rel2_level", u_if.Btn_Level, 0);

    // Reset during PRESS_WAIT with cnt=2, button held through reset
    drive_watch(5, 16'h0001, 1);
    chk("mid_no_press", press_cnt, 0);
    tick_reset(1);
    chk("mid_rst_press", u_if.Press_Pulse, 0);
    chk("mid_rst_level", u_if.Btn_Level,   0);
    drive_watch(10, 16'h0001, 1);
    chk("mid_after_count", press_cnt, 1);
    chk("mid_after_edge",  press_at,  7);

    // Downstream toggle flip-flop
    u_if.Btn_In = 1'b0;
    tick_reset(2);
    chk("tog_reset", r_tq, 0);
    drive_watch(10, 16'h0001, 1);
    chk("tog_press1", r_tq, 1);
    drive_watch(10, 16'h0000, 1);
    drive_watch(10, 16'h0001, 1);
    chk("tog_press2", r_tq, 0);
    drive_watch(10, 16'h0000, 1);
    drive_watch(10, 16'h0001, 1);
    chk("tog_press3", r_tq, 1);
    drive_watch(10, 16'h0000, 1);
    chk("tog_release_hold", r_tq, 1);

    chk("pulse_rules", rule_viol, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
